pc_branch_ctrl: RTL and testbench

//   Parametrised program counter with branch/jump control. Each enabled cycle the PC

---
 rtl/pc_branch_ctrl.sv | 92 +++++++++
 tb/tb_pc_branch_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pc_branch_ctrl.sv
// Program counter with jump, conditional branch and call/return sequencing.
// Redirects land on pc one cycle after the strobe and are flagged by taken.
module pc_branch_ctrl #(
    parameter int unsigned                PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0]        RESET_VEC   = '0,
    parameter int unsigned                STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                jump,
    input  logic                br_z,
    input  logic                br_nz,
    input  logic                call,
    input  logic                ret,
    input  logic                status,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                taken,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                stack_err
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
    logic [DW-1:0]       depth;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] top;
    logic                br_ok;
    logic                push;

    assign pc_inc      = pc + 1'b1;
    assign stack_full  = (depth == FULL);
    assign stack_empty = (depth == '0);
    assign br_ok       = (br_z & status) | (br_nz & ~status);
    assign push        = en & ~reset & ~ret & call & ~stack_full;

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth == DW'(i + 1)) top = stack[i];
        end
    end

    // Stack contents need no reset; depth alone decides validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && depth == DW'(i)) stack[i] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_VEC;
            taken     <= 1'b0;
            depth     <= '0;
            stack_err <= 1'b0;
        end else if (!en) begin
            taken <= 1'b0;
        end else if (ret) begin
            if (stack_empty) begin
                pc        <= pc_inc;
                taken     <= 1'b0;
                stack_err <= 1'b1;
            end else begin
                pc    <= top;
                depth <= depth - 1'b1;
                taken <= 1'b1;
            end
        end else if (call) begin
            if (stack_full) begin
                pc        <= pc_inc;
                taken     <= 1'b0;
                stack_err <= 1'b1;
            end else begin
                pc    <= target;
                depth <= depth + 1'b1;
                taken <= 1'b1;
            end
        end else if (jump || ((br_z || br_nz) && br_ok)) begin
            pc    <= target;
            taken <= 1'b1;
        end else begin
            pc    <= pc_inc;
            taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed bench for pc_branch_ctrl: sequencing, branches,
// return stack overflow/underflow, priority, stall and wrap.
module tb_pc_branch_ctrl;

    logic       clk = 1'b0;
    logic       reset, en, jump, br_z, br_nz, call, ret, status;
    logic [7:0] target;
    logic [7:0] pc;
    logic       taken, stack_full, stack_empty, stack_err;

    int tests = 0;
    int fails = 0;

    pc_branch_ctrl #(
        .PC_WIDTH(8), .RESET_VEC(8'h00), .STACK_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .jump(jump),
        .br_z(br_z), .br_nz(br_nz), .call(call), .ret(ret),
        .status(status), .target(target), .pc(pc), .taken(taken),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        jump = 0; br_z = 0; br_nz = 0; call = 0; ret = 0;
        status = 0; target = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic chk_pt(input string tag, input logic [7:0] p,
                          input logic t);
        chk({tag, "_pc"}, pc, p);
        chk({tag, "_taken"}, {7'd0, taken}, {7'd0, t});
    endtask

    initial begin
        reset = 1; en = 1; clr();
        #2;
        // 1: reset then free-running increment with wrap
        step();
        chk_pt("rst", 8'h00, 1'b0);
        chk("rst_empty", {7'd0, stack_empty}, 8'd1);
        chk("rst_full", {7'd0, stack_full}, 8'd0);
        chk("rst_err", {7'd0, stack_err}, 8'd0);
        reset = 0;
        for (int i = 1; i <= 260; i++) begin
            step();
            chk_pt("incr", 8'(i), 1'b0);
        end

        // 2: conditional branches
        jump = 1; target = 8'h10; step();
        chk_pt("jmp10", 8'h10, 1'b1);
        br_z = 1; status = 0; target = 8'h40; step();
        chk_pt("bz_nt", 8'h11, 1'b0);
        br_z = 1; status = 1; target = 8'h40; step();
        chk_pt("bz_t", 8'h40, 1'b1);
        step();
        chk_pt("bz_after", 8'h41, 1'b0);
        br_nz = 1; status = 0; target = 8'h60; step();
        chk_pt("bnz_t", 8'h60, 1'b1);
        br_nz = 1; status = 1; target = 8'h70; step();
        chk_pt("bnz_nt", 8'h61, 1'b0);
        br_z = 1; br_nz = 1; status = 1; target = 8'h33; step();
        chk_pt("bboth", 8'h33, 1'b1);

        // 3: nested call/return
        jump = 1; target = 8'h05; step();
        chk_pt("jmp05", 8'h05, 1'b1);
        call = 1; target = 8'h80; step();
        chk_pt("call80", 8'h80, 1'b1);
        call = 1; target = 8'h90; step();
        chk_pt("call90", 8'h90, 1'b1);
        ret = 1; step();
        chk_pt("ret1", 8'h81, 1'b1);
        ret = 1; step();
        chk_pt("ret2", 8'h06, 1'b1);
        chk("n_empty", {7'd0, stack_empty}, 8'd1);
        chk("n_err", {7'd0, stack_err}, 8'd0);

        // 4: overflow and underflow
        call = 1; target = 8'h10; step();
        call = 1; target = 8'h20; step();
        call = 1; target = 8'h30; step();
        chk("full3", {7'd0, stack_full}, 8'd0);
        call = 1; target = 8'h40; step();
        chk_pt("call4", 8'h40, 1'b1);
        chk("full4", {7'd0, stack_full}, 8'd1);
        call = 1; target = 8'h50; step();
        chk_pt("call5", 8'h41, 1'b0);
        chk("ovf_err", {7'd0, stack_err}, 8'd1);
        ret = 1; step(); chk_pt("pop1", 8'h31, 1'b1);
        ret = 1; step(); chk_pt("pop2", 8'h21, 1'b1);
        ret = 1; step(); chk_pt("pop3", 8'h11, 1'b1);
        ret = 1; step(); chk_pt("pop4", 8'h07, 1'b1);
        chk("pop_empty", {7'd0, stack_empty}, 8'd1);
        ret = 1; step();
        chk_pt("unf", 8'h08, 1'b0);
        chk("unf_err", {7'd0, stack_err}, 8'd1);

        // 5: priority, stall, reset mid-stack
        reset = 1; step(); reset = 0;
        chk_pt("rst2", 8'h00, 1'b0);
        chk("rst2_err", {7'd0, stack_err}, 8'd0);
        call = 1; target = 8'h30; step();
        chk_pt("pcall", 8'h30, 1'b1);
        ret = 1; call = 1; jump = 1; target = 8'h70; step();
        chk_pt("prio", 8'h01, 1'b1);
        chk("prio_empty", {7'd0, stack_empty}, 8'd1);
        chk("prio_err", {7'd0, stack_err}, 8'd0);
        en = 0; jump = 1; target = 8'h55; step();
        chk_pt("stall", 8'h01, 1'b0);
        en = 1; call = 1; target = 8'h30; step();
        chk_pt("call_b", 8'h30, 1'b1);
        chk("mid_empty", {7'd0, stack_empty}, 8'd0);
        reset = 1; en = 0; step(); reset = 0; en = 1;
        chk_pt("rst3", 8'h00, 1'b0);
        chk("rst3_empty", {7'd0, stack_empty}, 8'd1);
        chk("rst3_err", {7'd0, stack_err}, 8'd0);

        // 6: return address wraps
        jump = 1; target = 8'hFF; step();
        chk_pt("jmpff", 8'hFF, 1'b1);
        call = 1; target = 8'h20; step();
        chk_pt("callw", 8'h20, 1'b1);
        ret = 1; step();
        chk_pt("retw", 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
